// File: rtl/op_unit_mc.sv
// Multi-channel arithmetic engine: per-channel operand/result register banks
// sharing one multi-cycle add/sub/mul/compare datapath.

module op_unit_mc_ch #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          we_mode,
  input  logic          we_opa,
  input  logic          we_opb,
  input  logic [DW-1:0] wdata,
  input  logic          start,
  input  logic          rej,
  input  logic          cmpl,
  input  logic [DW-1:0] cres,
  input  logic          covf,
  input  logic          rclr,
  output logic [1:0]    mode,
  output logic [DW-1:0] opa,
  output logic [DW-1:0] opb,
  output logic [DW-1:0] res,
  output logic          done,
  output logic          err,
  output logic          ovf
);
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mode <= '0;
      opa  <= '0;
      opb  <= '0;
      res  <= '0;
      done <= 1'b0;
      err  <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      if (we_mode) mode <= wdata[1:0];
      if (we_opa)  opa  <= wdata;
      if (we_opb)  opb  <= wdata;
      if (start) begin
        done <= 1'b0;
        err  <= 1'b0;
        ovf  <= 1'b0;
      end
      if (rej) err <= 1'b1;
      // completion set is ordered after read-clear so it wins
      if (rclr) done <= 1'b0;
      if (cmpl) begin
        res  <= cres;
        ovf  <= covf;
        done <= 1'b1;
      end
    end
  end
endmodule

module op_unit_mc #(
  parameter int DW  = 32,
  parameter int NCH = 4,
  parameter int LAT = 3
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [$clog2(NCH)+2:0] addr,
  input  logic [DW-1:0]          wdata,
  input  logic                   wr,
  input  logic                   rd,
  output logic [DW-1:0]          rdata,
  output logic                   rvalid,
  output logic                   busy,
  output logic                   done_irq
);
  localparam int CW = $clog2(NCH);
  localparam int LW = $clog2(LAT+1);

  typedef enum logic {IDLE, EXEC} state_t;
  state_t state_q, state_d;

  logic [CW-1:0] ch;
  logic [2:0]    off;
  logic          wr_cmd, start, rej, cmpl, rd_ok;

  logic [LW-1:0] cnt;
  logic [DW-1:0] a_q, b_q;
  logic [1:0]    md_q, op_q;
  logic [CW-1:0] ch_q;

  logic [NCH-1:0][1:0]    mode_c;
  logic [NCH-1:0][DW-1:0] opa_c, opb_c, res_c;
  logic [NCH-1:0]         done_c, err_c, ovf_c;

  logic [DW-1:0] cres, rmux;
  logic          covf;

  assign ch     = addr[CW+2:3];
  assign off    = addr[2:0];
  assign wr_cmd = wr && (off == 3'd3);
  assign start  = wr_cmd && (state_q == IDLE);
  assign rej    = wr_cmd && (state_q == EXEC);
  assign cmpl   = (state_q == EXEC) && (cnt == LW'(1));
  assign rd_ok  = rd && !wr;
  assign busy   = (state_q == EXEC);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic sel, csel;
    assign sel  = (ch == CW'(i));
    assign csel = (ch_q == CW'(i));
    op_unit_mc_ch #(.DW(DW)) u_ch (
      .clk     (clk),
      .rstn    (rstn),
      .we_mode (wr && sel && off == 3'd0),
      .we_opa  (wr && sel && off == 3'd1),
      .we_opb  (wr && sel && off == 3'd2),
      .wdata   (wdata),
      .start   (start && sel),
      .rej     (rej && sel),
      .cmpl    (cmpl && csel),
      .cres    (cres),
      .covf    (covf),
      .rclr    (rd_ok && sel && off == 3'd3),
      .mode    (mode_c[i]),
      .opa     (opa_c[i]),
      .opb     (opb_c[i]),
      .res     (res_c[i]),
      .done    (done_c[i]),
      .err     (err_c[i]),
      .ovf     (ovf_c[i])
    );
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = EXEC;
      EXEC:    if (cmpl)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      md_q     <= '0;
      op_q     <= '0;
      ch_q     <= '0;
      done_irq <= 1'b0;
    end else begin
      done_irq <= cmpl;
      if (start) begin
        cnt  <= LW'(LAT);
        a_q  <= opa_c[ch];
        b_q  <= opb_c[ch];
        md_q <= mode_c[ch];
        op_q <= wdata[1:0];
        ch_q <= ch;
      end else if (state_q == EXEC) begin
        cnt <= cnt - LW'(1);
      end
    end
  end

  // Datapath works on the latched operands, so later register writes can't disturb it.
  logic            sgn, sat, sat_hi, lt;
  logic [DW:0]     sum_u, dif_u;
  logic [2*DW-1:0] ax, bx, prod;
  logic [DW-1:0]   raw;

  always_comb begin
    sgn   = md_q[0];
    sat   = md_q[1];
    sum_u = {1'b0, a_q} + {1'b0, b_q};
    dif_u = {1'b0, a_q} - {1'b0, b_q};
    ax    = sgn ? {{DW{a_q[DW-1]}}, a_q} : {{DW{1'b0}}, a_q};
    bx    = sgn ? {{DW{b_q[DW-1]}}, b_q} : {{DW{1'b0}}, b_q};
    prod  = ax * bx;
    lt    = sgn ? ($signed(a_q) < $signed(b_q)) : (a_q < b_q);
    raw    = '0;
    covf   = 1'b0;
    sat_hi = 1'b0;
    case (op_q)
      2'b00: begin
        raw    = sum_u[DW-1:0];
        covf   = sgn ? (a_q[DW-1] == b_q[DW-1]) && (raw[DW-1] != a_q[DW-1]) : sum_u[DW];
        sat_hi = sgn ? !a_q[DW-1] : 1'b1;
      end
      2'b01: begin
        raw    = dif_u[DW-1:0];
        covf   = sgn ? (a_q[DW-1] != b_q[DW-1]) && (raw[DW-1] != a_q[DW-1]) : dif_u[DW];
        sat_hi = sgn ? !a_q[DW-1] : 1'b0;
      end
      2'b10: begin
        raw    = prod[DW-1:0];
        covf   = sgn ? (prod[2*DW-1:DW] != {DW{prod[DW-1]}}) : (|prod[2*DW-1:DW]);
        sat_hi = sgn ? !(a_q[DW-1] ^ b_q[DW-1]) : 1'b1;
      end
      default: raw = {{(DW-1){1'b0}}, lt};
    endcase
    cres = raw;
    if (sat && covf) begin
      if (sgn) cres = sat_hi ? {1'b0, {(DW-1){1'b1}}} : {1'b1, {(DW-1){1'b0}}};
      else     cres = sat_hi ? {DW{1'b1}} : {DW{1'b0}};
    end
  end

  always_comb begin
    rmux = '0;
    case (off)
      3'd0:    rmux = {{(DW-2){1'b0}}, mode_c[ch]};
      3'd1:    rmux = opa_c[ch];
      3'd2:    rmux = opb_c[ch];
      3'd3:    rmux = {{(DW-4){1'b0}}, busy && (ch_q == ch), ovf_c[ch], err_c[ch], done_c[ch]};
      3'd4:    rmux = res_c[ch];
      default: rmux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= rd_ok;
      if (rd_ok) rdata <= rmux;
    end
  end
endmodule

// File: tb/tb_op_unit_mc.sv
// Directed bench for op_unit_mc with a read-data scoreboard.

module tb_op_unit_mc;
  localparam int DW = 32, NCH = 4, LAT = 3;

  logic          clk = 1'b0;
  logic          rstn;
  logic [4:0]    addr;
  logic [DW-1:0] wdata;
  logic          wr, rd;
  logic [DW-1:0] rdata;
  logic          rvalid, busy, done_irq;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] sb[$];

  op_unit_mc #(.DW(DW), .NCH(NCH), .LAT(LAT)) dut (
    .clk(clk), .rstn(rstn), .addr(addr), .wdata(wdata), .wr(wr), .rd(rd),
    .rdata(rdata), .rvalid(rvalid), .busy(busy), .done_irq(done_irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_reg(input logic [1:0] ch, input logic [2:0] off, input logic [DW-1:0] d);
    addr = {ch, off}; wdata = d; wr = 1'b1;
    tick();
    wr = 1'b0;
  endtask

  task automatic rd_reg(input string tag, input logic [1:0] ch, input logic [2:0] off,
                        input logic [DW-1:0] exp);
    logic [DW-1:0] e;
    sb.push_back(exp);
    addr = {ch, off}; rd = 1'b1;
    tick();
    rd = 1'b0;
    chk({tag, "_rvalid"}, {31'd0, rvalid}, 32'd1);
    if (rvalid && sb.size() > 0) begin
      e = sb.pop_front();
      chk(tag, rdata, e);
    end
  endtask

  // Start an op and wait (bounded) for completion; checks busy length and irq count.
  task automatic run_op(input string tag, input logic [1:0] ch, input logic [1:0] op,
                        input logic [DW-1:0] exp_res, input logic [DW-1:0] exp_st);
    int n, irqs;
    n = 0; irqs = 0;
    wr_reg(ch, 3'd3, {30'd0, op});
    while (busy && n < 20) begin
      tick(); n++;
      if (done_irq) irqs++;
    end
    chk({tag, "_busy_cycles"}, n, LAT);
    chk({tag, "_irqs"}, irqs, 1);
    tick();
    chk({tag, "_irq_pulse"}, {31'd0, done_irq}, 32'd0);
    rd_reg({tag, "_result"}, ch, 3'd4, exp_res);
    rd_reg({tag, "_status"}, ch, 3'd3, exp_st);
  endtask

  initial begin
    int n, irqs;
    logic [DW-1:0] hold;
    rstn = 1'b0; addr = '0; wdata = '0; wr = 1'b0; rd = 1'b0;
    #12;
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_flags", {29'd0, rvalid, busy, done_irq}, 32'd0);
    rstn = 1'b1;
    tick();
    for (int c = 0; c < NCH; c++) rd_reg("rst_status", 2'(c), 3'd3, 32'd0);

    // unsigned add with carry, then saturating
    wr_reg(2'd0, 3'd0, 32'd0);
    wr_reg(2'd0, 3'd1, 32'hFFFF_FFFF);
    wr_reg(2'd0, 3'd2, 32'd2);
    run_op("add_u", 2'd0, 2'b00, 32'h0000_0001, 32'h5);
    rd_reg("rtc_status", 2'd0, 3'd3, 32'h4);
    wr_reg(2'd0, 3'd0, 32'd2);
    run_op("add_u_sat", 2'd0, 2'b00, 32'hFFFF_FFFF, 32'h5);

    // signed mul and signed saturating add
    wr_reg(2'd1, 3'd0, 32'd1);
    wr_reg(2'd1, 3'd1, 32'hFFFF_FFFE);
    wr_reg(2'd1, 3'd2, 32'd3);
    run_op("mul_s", 2'd1, 2'b10, 32'hFFFF_FFFA, 32'h1);
    wr_reg(2'd1, 3'd0, 32'd3);
    wr_reg(2'd1, 3'd1, 32'h7FFF_FFFF);
    wr_reg(2'd1, 3'd2, 32'd1);
    run_op("add_s_sat", 2'd1, 2'b00, 32'h7FFF_FFFF, 32'h5);

    // sub borrow, compares, unsigned mul saturation on ch3
    wr_reg(2'd3, 3'd0, 32'd0);
    wr_reg(2'd3, 3'd1, 32'd5);
    wr_reg(2'd3, 3'd2, 32'd7);
    run_op("sub_u", 2'd3, 2'b01, 32'hFFFF_FFFE, 32'h5);
    wr_reg(2'd3, 3'd0, 32'd1);
    wr_reg(2'd3, 3'd1, 32'hFFFF_FFFF);
    wr_reg(2'd3, 3'd2, 32'd1);
    run_op("cmp_s", 2'd3, 2'b11, 32'd1, 32'h1);
    wr_reg(2'd3, 3'd0, 32'd0);
    run_op("cmp_u", 2'd3, 2'b11, 32'd0, 32'h1);
    wr_reg(2'd3, 3'd0, 32'd2);
    wr_reg(2'd3, 3'd1, 32'h0001_0000);
    wr_reg(2'd3, 3'd2, 32'h0001_0000);
    run_op("mul_u_sat", 2'd3, 2'b10, 32'hFFFF_FFFF, 32'h5);

    // rejected CMD on ch2 plus OPA rewrite while ch0 is executing
    wr_reg(2'd0, 3'd0, 32'd0);
    wr_reg(2'd0, 3'd1, 32'd10);
    wr_reg(2'd0, 3'd2, 32'd20);
    wr_reg(2'd0, 3'd3, 32'd0);
    wr_reg(2'd2, 3'd3, 32'd1);
    wr_reg(2'd0, 3'd1, 32'd999);
    n = 0; irqs = 0;
    while (busy && n < 20) begin
      tick(); n++;
      if (done_irq) irqs++;
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      if (done_irq) irqs++;
    end
    chk("rej_irqs", irqs, 1);
    rd_reg("rej_ch2_status", 2'd2, 3'd3, 32'h2);
    rd_reg("rej_ch0_result", 2'd0, 3'd4, 32'd30);
    rd_reg("rej_ch0_status", 2'd0, 3'd3, 32'h1);
    rd_reg("rej_ch0_opa", 2'd0, 3'd1, 32'd999);

    // STATUS read landing on the completion edge
    wr_reg(2'd1, 3'd0, 32'd0);
    wr_reg(2'd1, 3'd1, 32'd1);
    wr_reg(2'd1, 3'd2, 32'd1);
    wr_reg(2'd1, 3'd3, 32'd0);
    for (int k = 0; k < LAT-1; k++) tick();
    rd_reg("cmpl_rd_status", 2'd1, 3'd3, 32'h8);
    chk("cmpl_rd_irq", {31'd0, done_irq}, 32'd1);
    rd_reg("cmpl_rd_status2", 2'd1, 3'd3, 32'h1);
    rd_reg("cmpl_rd_status3", 2'd1, 3'd3, 32'h0);

    // wr+rd together, unmapped offsets, rdata hold
    addr = {2'd0, 3'd1}; wdata = 32'hA5A5_0001; wr = 1'b1; rd = 1'b1;
    tick();
    wr = 1'b0; rd = 1'b0;
    chk("wrrd_rvalid", {31'd0, rvalid}, 32'd0);
    rd_reg("wrrd_opa", 2'd0, 3'd1, 32'hA5A5_0001);
    hold = 32'hA5A5_0001;
    tick();
    chk("hold_rvalid", {31'd0, rvalid}, 32'd0);
    chk("hold_rdata", rdata, hold);
    wr_reg(2'd2, 3'd5, 32'h1234_5678);
    rd_reg("off5", 2'd2, 3'd5, 32'd0);
    rd_reg("off7", 2'd2, 3'd7, 32'd0);

    // reset during EXEC cycle 2
    wr_reg(2'd3, 3'd0, 32'd0);
    wr_reg(2'd3, 3'd1, 32'd3);
    wr_reg(2'd3, 3'd2, 32'd4);
    wr_reg(2'd3, 3'd3, 32'd0);
    tick();
    rstn = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_irq", {31'd0, done_irq}, 32'd0);
    chk("arst_rdata", rdata, 32'd0);
    #2 rstn = 1'b1;
    irqs = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (done_irq || busy) irqs++;
    end
    chk("arst_no_irq", irqs, 0);
    rd_reg("arst_result", 2'd3, 3'd4, 32'd0);
    rd_reg("arst_status", 2'd3, 3'd3, 32'd0);
    rd_reg("arst_opa", 2'd3, 3'd1, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
